muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide unit; multi-cycle companion to the single-cycle ALU in the execute stage.
- The datapath issues an operation with a Start pulse and waits on Busy/Done.
- Handles all eight M-extension funct3 ops with one shared 32-iteration shift/add–subtract engine.
- Sign handling is done by magnitude conversion before iterating and fix-up afterwards.

---
 rtl/muldiv_pkg.sv | 29 ++
 rtl/md_sign_fix.sv | 46 ++++
 rtl/muldiv_unit.sv | 139 +++++++++++++
 tb/tb_muldiv_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  // funct3 encodings of the M extension
  typedef enum logic [2:0] {
    OpMul    = 3'b000,
    OpMulh   = 3'b001,
    OpMulhsu = 3'b010,
    OpMulhu  = 3'b011,
    OpDiv    = 3'b100,
    OpDivu   = 3'b101,
    OpRem    = 3'b110,
    OpRemu   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } md_state_e;

  localparam logic [31:0] DIV_OVF_DIVIDEND = 32'h8000_0000;

  function automatic logic op_is_div(input md_op_e op);
    return op inside {OpDiv, OpDivu, OpRem, OpRemu};
  endfunction

endpackage

// File: rtl/md_sign_fix.sv
// md_sign_fix: combinational post-processing for the FIX state. Restores result sign,
// selects the product half and applies divide-by-zero / signed-overflow overrides.
import muldiv_pkg::*;

module md_sign_fix #(
  parameter int unsigned XLEN = 32
) (
  input  md_op_e              op,
  input  logic [2*XLEN-1:0]   acc,
  input  logic                sa,
  input  logic                sb,
  input  logic                div_zero,
  input  logic                ovf,
  input  logic [XLEN-1:0]     a_raw,
  output logic [XLEN-1:0]     result
);

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;

  // Negate magnitudes back to signed results, then pick the field the op wants
  always_comb begin
    // sb is latched as 0 for unsigned operands, so sa^sb covers MULHSU/MULHU too
    prod   = (sa ^ sb) ? -acc : acc;
    quo    = (sa ^ sb) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem    = sa ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    result = '0;
    case (op)
      OpMul:                     result = prod[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu: result = prod[2*XLEN-1:XLEN];
      OpDiv, OpDivu: begin
        if (div_zero)  result = '1;
        else if (ovf)  result = XLEN'(DIV_OVF_DIVIDEND);
        else           result = quo;
      end
      OpRem, OpRemu: begin
        if (div_zero)  result = a_raw;
        else if (ovf)  result = '0;
        else           result = rem;
      end
      default:           result = '0;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, one shift-add / restoring step per cycle.
// Define MULDIV_EARLY_OUT_EN to skip iteration for zero operands and special divide cases.
import muldiv_pkg::*;

module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Start,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic [2:0]      MDControl,
  output logic            Busy,
  output logic            Done,
  output logic [XLEN-1:0] MDResult
);

  localparam int unsigned CW = $clog2(XLEN);

  md_state_e         state_q, state_d;
  md_op_e            op_q, op_in;
  logic              sa_q, sb_q, div_zero_q, ovf_q;
  logic [XLEN-1:0]   a_raw_q, opnd_q, result_q, fix_result;
  logic [2*XLEN-1:0] acc_q, acc_step, acc_load;
  logic [CW-1:0]     count_q;

  logic              a_signed, b_signed, sa_in, sb_in, is_div_in;
  logic              div_zero_in, ovf_in, early_in;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum, rem_sh, rem_diff;

  // Decode the incoming request: signedness, magnitudes, special cases
  always_comb begin
    op_in       = md_op_e'(MDControl);
    is_div_in   = op_is_div(op_in);
    a_signed    = op_in inside {OpMul, OpMulh, OpMulhsu, OpDiv, OpRem};
    b_signed    = op_in inside {OpMul, OpMulh, OpDiv, OpRem};
    sa_in       = a_signed & SrcA[XLEN-1];
    sb_in       = b_signed & SrcB[XLEN-1];
    a_mag       = sa_in ? -SrcA : SrcA;
    b_mag       = sb_in ? -SrcB : SrcB;
    div_zero_in = is_div_in & (SrcB == '0);
    ovf_in      = (op_in inside {OpDiv, OpRem}) & (SrcA == XLEN'(DIV_OVF_DIVIDEND)) &
                  (SrcB == '1);
`ifdef MULDIV_EARLY_OUT_EN
    early_in    = is_div_in ? (div_zero_in | ovf_in | (SrcA == '0))
                            : ((SrcA == '0) | (SrcB == '0));
`else
    early_in    = 1'b0;
`endif
    // Low half holds the multiplier or dividend; a zeroed accumulator is the
    // correct raw answer for every early-out case that is not overridden in FIX
    acc_load    = early_in ? '0 : {{XLEN{1'b0}}, is_div_in ? a_mag : b_mag};
  end

  // One iteration of the shared engine: shift-add for MUL, restoring step for DIV
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    rem_diff = rem_sh - {1'b0, opnd_q};
    if (op_is_div(op_q)) begin
      acc_step = rem_diff[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                : {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      acc_step = {mul_sum, acc_q[XLEN-1:1]};
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (Start) state_d = early_in ? FIX : CALC;
      CALC: if (count_q == CW'(XLEN - 1)) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  md_sign_fix #(
    .XLEN(XLEN)
  ) u_sign_fix (
    .op       (op_q),
    .acc      (acc_q),
    .sa       (sa_q),
    .sb       (sb_q),
    .div_zero (div_zero_q),
    .ovf      (ovf_q),
    .a_raw    (a_raw_q),
    .result   (fix_result)
  );

  // State, operand latch, iteration and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= OpMul;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
      a_raw_q    <= '0;
      opnd_q     <= '0;
      acc_q      <= '0;
      count_q    <= '0;
      result_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (Start) begin
            op_q       <= op_in;
            sa_q       <= sa_in;
            sb_q       <= sb_in;
            div_zero_q <= div_zero_in;
            ovf_q      <= ovf_in;
            a_raw_q    <= SrcA;
            opnd_q     <= is_div_in ? b_mag : a_mag;
            acc_q      <= acc_load;
            count_q    <= '0;
          end
        end
        CALC: begin
          acc_q   <= acc_step;
          count_q <= count_q + CW'(1);
        end
        FIX:     result_q <= fix_result;
        default: ;
      endcase
    end
  end

  assign Busy     = (state_q != IDLE);
  assign Done     = (state_q == DONE);
  assign MDResult = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors with literal expectations plus a cycle-level reference
// model (plain 64-bit arithmetic and a latency counter) checked on every negative edge.
module tb_muldiv_unit;

  localparam int LAT = 34;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int LAT_EARLY = 2;
`else
  localparam int LAT_EARLY = 34;
`endif

  logic        clk = 1'b0;
  logic        reset, Start;
  logic [31:0] SrcA, SrcB;
  logic [2:0]  MDControl;
  logic        Busy, Done;
  logic [31:0] MDResult;

  int vectors = 0;
  int errors  = 0;

  muldiv_unit #(
    .XLEN(32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .Start     (Start),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .MDControl (MDControl),
    .Busy      (Busy),
    .Done      (Done),
    .MDResult  (MDResult)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of an M-extension op
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          as, bs, au, bu;
    longint unsigned xu, yu;
    logic [63:0]     w;
    as = $signed(a);
    bs = $signed(b);
    au = {32'd0, a};
    bu = {32'd0, b};
    xu = {32'd0, a};
    yu = {32'd0, b};
    w  = '0;
    case (op)
      3'd0: begin w = as * bs; return w[31:0]; end
      3'd1: begin w = as * bs; return w[63:32]; end
      3'd2: begin w = as * bu; return w[63:32]; end
      3'd3: begin w = xu * yu; return w[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        w = as / bs; return w[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        w = au / bu; return w[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        w = as % bs; return w[31:0];
      end
      default: begin
        if (b == 0) return a;
        w = au % bu; return w[31:0];
      end
    endcase
  endfunction

  // Edges from accept until Done is sampled high
  function automatic int lat_of(input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    if (op[2]) begin
      if (b == 0 || a == 0) return 2;
      if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    end else if (a == 0 || b == 0) begin
      return 2;
    end
`endif
    return LAT + 0 * op;
  endfunction

  // Reference model timeline, advanced on each rising edge
  bit          m_valid = 0, m_busy = 0;
  int          m_since = 0, m_lat = LAT;
  logic [31:0] m_pend = '0, m_held = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1;
      m_busy  = 0;
      m_held  = '0;
    end else if (!m_busy) begin
      if (Start === 1'b1) begin
        m_busy  = 1;
        m_since = 0;
        m_pend  = model(MDControl, SrcA, SrcB);
        m_lat   = lat_of(MDControl, SrcA, SrcB);
      end
    end else begin
      m_since++;
      if (m_since == m_lat - 1) m_held = m_pend;
      if (m_since == m_lat) m_busy = 0;
    end
  end

  // Compare every output against the model away from the active edge
  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", {31'd0, Busy}, {31'd0, m_busy});
      chk("done", {31'd0, Done}, {31'd0, (m_busy && m_since == m_lat - 1)});
      chk("result", MDResult, m_held);
    end
  end

  // Issue at the current negedge; return at the negedge after Done
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input string name);
    int k;
    bit seen;
    MDControl = op;
    SrcA      = a;
    SrcB      = b;
    Start     = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    k     = 1;
    seen  = 0;
    while (k < 100 && !seen) begin
      if (Done) seen = 1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    chk({name, " seen"}, {31'd0, seen}, 32'd1);
    chk({name, " latency"}, 32'(k), 32'(lat));
    chk({name, " value"}, MDResult, exp);
    @(negedge clk);
    chk({name, " done pulse"}, {31'd0, Done}, 32'd0);
    chk({name, " busy fall"}, {31'd0, Busy}, 32'd0);
  endtask

  initial begin
    int k;
    int dones;
    bit seen;
    reset     = 1'b1;
    Start     = 1'b0;
    SrcA      = '0;
    SrcB      = '0;
    MDControl = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", {31'd0, Busy}, 32'd0);
    chk("reset done", {31'd0, Done}, 32'd0);
    chk("reset result", MDResult, 32'd0);
    reset = 1'b0;

    // Each run_op returns at the first idle cycle, so these issue back-to-back
    run_op(3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT,       "mul");
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT,       "mulh");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT,       "mulhu");
    run_op(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, LAT,       "mulhsu");
    run_op(3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, LAT,       "mulh neg");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, LAT,       "div");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, LAT,       "rem");
    run_op(3'd5, 32'd100,       32'd7,         32'h0000_000E, LAT,       "divu");
    run_op(3'd7, 32'd100,       32'd7,         32'd2,         LAT,       "remu");
    run_op(3'd5, 32'd100,       32'd0,         32'hFFFF_FFFF, LAT_EARLY, "divu by 0");
    run_op(3'd7, 32'd100,       32'd0,         32'h0000_0064, LAT_EARLY, "remu by 0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_EARLY, "div ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         LAT_EARLY, "rem ovf");
    run_op(3'd0, 32'd0,         32'd5,         32'h0,         LAT_EARLY, "mul zero");
    run_op(3'd4, 32'd0,         32'd5,         32'h0,         LAT_EARLY, "div zero dividend");
    run_op(3'd6, 32'hFFFF_FFF0, 32'd5,         32'hFFFF_FFFF, LAT,       "rem neg");

    // Start held high and operands scrambled while busy
    MDControl = 3'd0;
    SrcA      = 32'd7;
    SrcB      = 32'hFFFF_FFFD;
    Start     = 1'b1;
    @(negedge clk);
    k    = 1;
    seen = 0;
    while (k < 100 && !seen) begin
      SrcA      = $urandom;
      SrcB      = $urandom;
      MDControl = 3'($urandom_range(7, 0));
      if (Done) seen = 1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    Start = 1'b0;
    chk("hold latency", 32'(k), 32'(LAT));
    chk("hold value", MDResult, 32'hFFFF_FFEB);
    @(negedge clk);
    chk("hold busy fall", {31'd0, Busy}, 32'd0);
    chk("hold result kept", MDResult, 32'hFFFF_FFEB);

    // Reset sampled at edge 10 of an op aborts it
    MDControl = 3'd5;
    SrcA      = 32'd100;
    SrcB      = 32'd7;
    Start     = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort busy", {31'd0, Busy}, 32'd0);
    chk("abort result", MDResult, 32'd0);
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (Done) dones++;
    end
    chk("abort no done", 32'(dones), 32'd0);
    run_op(3'd5, 32'd100, 32'd7, 32'h0000_000E, LAT, "after reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
